// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between fetch and load, one outstanding single-beat read
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        rd_err,
  output logic        busy,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_nx;
  logic owner_data;
  logic [3:0] starve_cnt;
  logic idle, pick_inst, beat;
  logic unused;
  assign unused = ^{rid, rlast};
  assign idle = state == IDLE;
  assign pick_inst = inst_req && (!data_req || starve_cnt == 4'(STARVE_LIMIT));
  assign inst_gnt = idle && pick_inst;
  assign data_gnt = idle && data_req && !pick_inst;
  // a beat without rlast still ends the burst: arlen is always 0
  assign beat = state == R && rvalid;
  assign arvalid = state == AR;
  assign rready = state == R;
  assign busy = !idle;
  assign arlen = 4'd0;
  assign arburst = 2'b01;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (inst_req || data_req) ? AR : IDLE;
      AR: state_nx = arready ? R : AR;
      R: state_nx = rvalid ? IDLE : R;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      owner_data <= 1'b0;
      starve_cnt <= 4'd0;
      araddr <= 32'd0;
      arid <= 4'd0;
      arsize <= 3'd0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      rd_err <= 1'b0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      state <= state_nx;
      inst_rvalid <= beat && !owner_data;
      data_rvalid <= beat && owner_data;
      rd_err <= beat && rresp != 2'b00;
      if (beat && owner_data) data_rdata <= rdata;
      if (beat && !owner_data) inst_rdata <= rdata;
      if (idle && (inst_req || data_req)) begin
        owner_data <= !pick_inst;
        araddr <= pick_inst ? inst_addr : data_addr;
        arid <= pick_inst ? INST_ID : DATA_ID;
        arsize <= pick_inst ? 3'd2 : data_size;
      end
      if (idle)
        starve_cnt <= (!inst_req || pick_inst) ? 4'd0 :
                      (starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1;
    end
  end
endmodule
